prbs_sched: RTL and testbench
=============================

Name: prbs_sched

Overview:
- Two-requester scheduler that shares one 8-bit PRBS pattern generator between two clients.
- Per job, it resets the generator, loads the requester's 32-bit seed pattern byte-serially, drives the pattern repeat count, and streams a fixed number of generator output bytes back to the granted requester.
- Sits between the client blocks and the generator. It is the only driver of the generator's reset, IN and n_pattern inputs.

Parameters:
- LEN_W, 16, width of the per-job stream length (bytes).
- RST_CYC, 2, cycles gen_rst_n is held low per job (legal range 1..15).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  active-low synchronous reset.
- req  in  2  req[i]=1: requester i wants a job; must hold until done[i].
- pattern0  in  32  requester 0 seed pattern; byte 0 = [7:0].
- pattern1  in  32  requester 1 seed pattern.
- n_pat0  in  8  requester 0 pattern repeat count.
- n_pat1  in  8  requester 1 pattern repeat count.
- len0  in  LEN_W  requester 0 stream length in bytes.
- len1  in  LEN_W  requester 1 stream length in bytes.
- gen_out  in  8  generator output byte.
- gen_rst_n  out  1  generator reset, active low.
- gen_in  out  8  generator pattern byte input.
- gen_n_pattern  out  8  generator repeat count.
- grant  out  2  one-hot owner of the generator; 0 when idle.
- out_valid  out  1  out_data valid this cycle.
- out_data  out  8  stream byte to the granted requester.
- done  out  2  one-cycle completion pulse per requester.
- aborted  out  1  qualifies done: job ended by req drop.

Behaviour:
- Reset (RST=0 at a clock edge), one cycle to take effect:
  - outputs: grant=0, gen_rst_n=0, gen_in=0, gen_n_pattern=0, out_valid=0, out_data=0, done=0, aborted=0.
  - state IDLE; rr pointer = 0 (requester 0 preferred).
- Reset mid-job abandons the job silently. No done pulse is issued.
- Job configuration (pattern, n_pat, len) is sampled into internal registers on the grant cycle. Later input changes are ignored for that job.
- The FSM below is registered. All outputs are registered.
- IDLE:
  - gen_rst_n=1.
  - If req!=0, grant one requester and go to GRST.
  - Single request: grant that requester.
  - Both requesting: grant requester rr.
- GRST: gen_rst_n=0 for RST_CYC cycles, then go to WAIT.
- WAIT: gen_rst_n=1, gen_n_pattern=sampled n_pat, 1 cycle, then go to LOAD.
- LOAD: 4 cycles.
  - gen_in = sampled pattern bytes 0,1,2,3 in that order.
  - 2-bit byte index wraps 3->0.
  - Then go to STREAM, or to DONE if sampled len=0.
- STREAM:
  - Each cycle: out_valid=1, out_data=gen_out (registered, 1-cycle latency).
  - LEN_W beat counter.
  - After exactly len beats go to DONE.
  - No backpressure.
- DONE:
  - done[granted]=1 for one cycle.
  - rr = other requester.
  - grant=0 on the next cycle. Return to IDLE; a new grant is possible the cycle after.
- Abort:
  - If req[granted] falls in any state other than IDLE or DONE, go to DONE next cycle with aborted=1 alongside done.
  - out_valid drops the same cycle DONE is entered.
- Simultaneous events:
  - A new req from the other requester during a job waits; it is served next because of the rr update.
  - req re-asserted by the same requester in DONE is not granted until IDLE, and loses to a waiting other requester.
- gen_n_pattern is held between jobs. gen_in returns to 0 outside LOAD.

Optional Feature:
- Macro: PRBS_SCHED_STATS_EN.
- Defined:
  - Adds outputs jobs0 and jobs1, 16 bits each.
  - Each is a saturating count (sticks at 16'hFFFF) of non-aborted completions for that requester.
  - Reset to 0 by RST.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then single job: req=2'b01, pattern0=32'hDEADBEEF, n_pat0=3, len0=10.
  - Required: grant=01; gen_rst_n low 2 cycles; gen_in sequence EF,BE,AD,DE.
  - Required: 10 out_valid beats mirroring gen_out; done=01, aborted=0; grant=0 next cycle.
- Contention: req=2'b11 from IDLE after reset, len0=len1=4.
  - Required: requester 0 served first, then requester 1, with no gap beyond one IDLE cycle.
  - Repeat with req1 held continuously: the grant order alternates 0,1,0,1.
- len1=0: req=2'b10.
  - Required: GRST, WAIT and 4 LOAD cycles, zero out_valid beats, then done=10.
- Abort: req0 dropped after 3 STREAM beats of len0=20.
  - Required: out_valid stops; done=01 with aborted=1.
  - With PRBS_SCHED_STATS_EN: jobs0 unchanged.
- Reset mid-LOAD: RST=0 for one cycle.
  - Required: all outputs at reset values next cycle; no done pulse; the next job starts cleanly with requester 0 preferred.
- Config change after grant: change pattern0 to 32'h01234567 during GRST.
  - Required: the LOAD bytes still come from the value sampled at grant.

Source files
------------

// File: rtl/prbs_sched.sv
// Two-requester round-robin scheduler sharing one 8-bit PRBS generator: per job it
// resets the generator, loads a 32-bit seed byte-serially, then streams len bytes back.
// Optional per-requester completion counters: define PRBS_SCHED_STATS_EN.
module prbs_sched #(
  parameter int LEN_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       req,
  input  logic [31:0]      pattern0,
  input  logic [31:0]      pattern1,
  input  logic [7:0]       n_pat0,
  input  logic [7:0]       n_pat1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       gen_out,
  output logic             gen_rst_n,
  output logic [7:0]       gen_in,
  output logic [7:0]       gen_n_pattern,
  output logic [1:0]       grant,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [1:0]       done,
  output logic             aborted
`ifdef PRBS_SCHED_STATS_EN
  ,
  output logic [15:0]      jobs0,
  output logic [15:0]      jobs1
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRST   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [3:0]       rst_cnt_q, rst_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [31:0]      pat_q, pat_d;
  logic [7:0]       npat_q, npat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       grant_q, grant_d;
  logic             gen_rst_n_q, gen_rst_n_d;
  logic [7:0]       gen_in_q, gen_in_d;
  logic [7:0]       gen_np_q, gen_np_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [1:0]       done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             sel;

  // out_valid has no ready: the client must take out_data on every cycle out_valid is high.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    rst_cnt_d   = rst_cnt_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    pat_d       = pat_q;
    npat_d      = npat_q;
    len_d       = len_q;
    grant_d     = grant_q;
    gen_rst_n_d = gen_rst_n_q;
    gen_in_d    = 8'h00;
    gen_np_d    = gen_np_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    done_d      = 2'b00;
    aborted_d   = 1'b0;
    sel         = 1'b0;

    case (state_q)
      S_IDLE: begin
        gen_rst_n_d = 1'b1;
        grant_d     = 2'b00;
        if (req != 2'b00) begin
          sel         = (req == 2'b11) ? rr_q : req[1];
          owner_d     = sel;
          grant_d     = sel ? 2'b10 : 2'b01;
          pat_d       = sel ? pattern1 : pattern0;
          npat_d      = sel ? n_pat1 : n_pat0;
          len_d       = sel ? len1 : len0;
          rst_cnt_d   = RST_LAST;
          gen_rst_n_d = 1'b0;
          state_d     = S_GRST;
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        grant_d     = 2'b00;
        rr_d        = ~owner_q;
        gen_rst_n_d = 1'b1;
      end

      S_GRST, S_WAIT, S_LOAD, S_STREAM: begin
        // Losing the owner's request preempts every other transition.
        if (!req[owner_q]) begin
          state_d     = S_DONE;
          done_d      = grant_q;
          aborted_d   = 1'b1;
          gen_rst_n_d = 1'b1;
        end else begin
          case (state_q)
            S_GRST: begin
              if (rst_cnt_q == 4'd0) begin
                state_d     = S_WAIT;
                gen_rst_n_d = 1'b1;
                gen_np_d    = npat_q;
              end else begin
                rst_cnt_d = rst_cnt_q - 4'd1;
              end
            end
            S_WAIT: begin
              state_d  = S_LOAD;
              idx_d    = 2'd0;
              gen_in_d = pat_q[7:0];
            end
            S_LOAD: begin
              idx_d = idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                if (len_q == '0) begin
                  state_d = S_DONE;
                  done_d  = grant_q;
                end else begin
                  state_d     = S_STREAM;
                  beat_d      = {{(LEN_W-1){1'b0}}, 1'b1};
                  out_valid_d = 1'b1;
                  out_data_d  = gen_out;
                end
              end else begin
                gen_in_d = pat_q[{idx_d, 3'b000} +: 8];
              end
            end
            default: begin
              if (beat_q == len_q) begin
                state_d = S_DONE;
                done_d  = grant_q;
              end else begin
                beat_d      = beat_q + 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = gen_out;
              end
            end
          endcase
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      rst_cnt_q   <= 4'd0;
      idx_q       <= 2'd0;
      beat_q      <= '0;
      pat_q       <= 32'h0;
      npat_q      <= 8'h00;
      len_q       <= '0;
      grant_q     <= 2'b00;
      gen_rst_n_q <= 1'b0;
      gen_in_q    <= 8'h00;
      gen_np_q    <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      done_q      <= 2'b00;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      rst_cnt_q   <= rst_cnt_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      pat_q       <= pat_d;
      npat_q      <= npat_d;
      len_q       <= len_d;
      grant_q     <= grant_d;
      gen_rst_n_q <= gen_rst_n_d;
      gen_in_q    <= gen_in_d;
      gen_np_q    <= gen_np_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign gen_rst_n     = gen_rst_n_q;
  assign gen_in        = gen_in_q;
  assign gen_n_pattern = gen_np_q;
  assign grant         = grant_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

`ifdef PRBS_SCHED_STATS_EN
  logic [15:0] jobs0_q, jobs0_d;
  logic [15:0] jobs1_q, jobs1_d;

  // Counted while sitting in DONE, so the new value shows the cycle after the done pulse.
  always_comb begin
    jobs0_d = jobs0_q;
    jobs1_d = jobs1_q;
    if (state_q == S_DONE && !aborted_q) begin
      if (!owner_q && jobs0_q != 16'hFFFF) jobs0_d = jobs0_q + 16'd1;
      if (owner_q && jobs1_q != 16'hFFFF)  jobs1_d = jobs1_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      jobs0_q <= 16'h0000;
      jobs1_q <= 16'h0000;
    end else begin
      jobs0_q <= jobs0_d;
      jobs1_q <= jobs1_d;
    end
  end

  assign jobs0 = jobs0_q;
  assign jobs1 = jobs1_q;
`endif

endmodule

// File: tb/tb_prbs_sched.sv
// Bench for prbs_sched: a job-timeline reference model checked every cycle, directed
// scenarios with literal expectations, then randomized requests, aborts and resets.
module tb_prbs_sched;
  localparam int LEN_W   = 16;
  localparam int RST_CYC = 2;

  logic             CLK;
  logic             RST;
  logic [1:0]       req;
  logic [31:0]      pattern0, pattern1;
  logic [7:0]       n_pat0, n_pat1;
  logic [LEN_W-1:0] len0, len1;
  logic [7:0]       gen_out;
  logic             gen_rst_n;
  logic [7:0]       gen_in;
  logic [7:0]       gen_n_pattern;
  logic [1:0]       grant;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [1:0]       done;
  logic             aborted;
`ifdef PRBS_SCHED_STATS_EN
  logic [15:0]      jobs0, jobs1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  prbs_sched #(.LEN_W(LEN_W), .RST_CYC(RST_CYC)) dut (
    .CLK(CLK), .RST(RST), .req(req),
    .pattern0(pattern0), .pattern1(pattern1),
    .n_pat0(n_pat0), .n_pat1(n_pat1),
    .len0(len0), .len1(len1),
    .gen_out(gen_out), .gen_rst_n(gen_rst_n), .gen_in(gen_in),
    .gen_n_pattern(gen_n_pattern), .grant(grant),
    .out_valid(out_valid), .out_data(out_data),
    .done(done), .aborted(aborted)
`ifdef PRBS_SCHED_STATS_EN
    , .jobs0(jobs0), .jobs1(jobs1)
`endif
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // A job is a timeline measured in cycles since grant: RST_CYC reset cycles, one
  // wait cycle, four load cycles, len stream cycles, then one done cycle.
  int          m_mode = 0;    // 0 idle, 1 in job, 2 done cycle
  int          m_t    = 0;
  int          m_own  = 0;
  int          m_rr   = 0;
  int          m_len  = 0;
  logic [31:0] m_pat  = '0;
  logic [7:0]  m_np   = '0;
  logic        m_ab   = 1'b0;
  logic [31:0] m_sh;
  int          e_jobs[2] = '{0, 0};
  logic [1:0]  e_grant = '0;
  logic        e_rst_n = 1'b0;
  logic [7:0]  e_in = '0, e_np = '0, e_data = '0;
  logic        e_valid = 1'b0, e_ab = 1'b0;
  logic [1:0]  e_done = '0;
  bit          started = 0;

  always @(posedge CLK) begin
    if (!RST) begin
      started = 1;
      m_mode = 0; m_rr = 0; m_t = 0;
      e_grant = 0; e_rst_n = 0; e_in = 0; e_np = 0; e_valid = 0;
      e_data = 0; e_done = 0; e_ab = 0;
      e_jobs[0] = 0; e_jobs[1] = 0;
    end else begin
      case (m_mode)
        0: begin
          e_done = 0; e_ab = 0; e_valid = 0; e_in = 0;
          if (req != 2'b00) begin
            m_own   = (req == 2'b11) ? m_rr : (req[1] ? 1 : 0);
            m_pat   = m_own ? pattern1 : pattern0;
            m_np    = m_own ? n_pat1 : n_pat0;
            m_len   = m_own ? int'(len1) : int'(len0);
            m_mode  = 1;
            m_t     = 0;
            e_grant = m_own ? 2'b10 : 2'b01;
            e_rst_n = 0;
          end else begin
            e_grant = 0;
            e_rst_n = 1;
          end
        end
        1: begin
          if (!req[m_own]) begin
            m_mode = 2; m_ab = 1;
            e_done = e_grant; e_ab = 1; e_valid = 0; e_in = 0; e_rst_n = 1;
          end else begin
            m_t = m_t + 1;
            e_in = 0; e_valid = 0;
            e_rst_n = (m_t < RST_CYC) ? 1'b0 : 1'b1;
            if (m_t == RST_CYC) e_np = m_np;
            if (m_t > RST_CYC && m_t <= RST_CYC + 4) begin
              m_sh = m_pat >> (8 * (m_t - RST_CYC - 1));
              e_in = m_sh[7:0];
            end
            if (m_t > RST_CYC + 4 && m_t <= RST_CYC + 4 + m_len) begin
              e_valid = 1; e_data = gen_out;
            end
            if (m_t == RST_CYC + 5 + m_len) begin
              m_mode = 2; m_ab = 0; e_done = e_grant; e_ab = 0;
            end
          end
        end
        default: begin
          if (!m_ab && e_jobs[m_own] < 65535) e_jobs[m_own] = e_jobs[m_own] + 1;
          e_grant = 0; e_done = 0; e_ab = 0; e_rst_n = 1;
          m_rr = 1 - m_own;
          m_mode = 0;
        end
      endcase
    end
  end

  // ---------------- compare process + monitors ----------------
  logic [30:0] act_v, exp_v;
  int          mon_rstlow, mon_beats, mon_gcycles, mon_idle, mon_ndone;
  logic [1:0]  mon_done, mon_gad, prev_grant;
  logic        mon_ab, prev_done;
  logic [7:0]  mon_inq[$];
  logic [1:0]  mon_order[$];

  always @(negedge CLK) begin
    if (started) begin
      act_v = {grant, gen_rst_n, gen_in, gen_n_pattern, out_valid, out_data, done, aborted};
      exp_v = {e_grant, e_rst_n, e_in, e_np, e_valid, e_data, e_done, e_ab};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t: got %h required %h", $time, act_v, exp_v);
      end
`ifdef PRBS_SCHED_STATS_EN
      n_tests++;
      if (jobs0 !== 16'(e_jobs[0]) || jobs1 !== 16'(e_jobs[1])) begin
        n_fail++;
        $display("FAIL jobs_compare t=%0t: got %0d/%0d required %0d/%0d",
                 $time, jobs0, jobs1, e_jobs[0], e_jobs[1]);
      end
`endif
    end
    if (grant != 0 && !gen_rst_n) mon_rstlow++;
    if (grant != 0 && gen_in != 0) mon_inq.push_back(gen_in);
    if (out_valid) mon_beats++;
    if (grant != 0) mon_gcycles++; else mon_idle++;
    if (prev_done) mon_gad = grant;
    if (grant != 0 && prev_grant == 0) mon_order.push_back(grant);
    if (done != 0) begin mon_done = done; mon_ab = aborted; mon_ndone++; end
    prev_done  = (done != 0);
    prev_grant = grant;
  end

  // ---------------- driver tasks ----------------
  task automatic mon_clear();
    mon_rstlow = 0; mon_beats = 0; mon_gcycles = 0; mon_idle = 0; mon_ndone = 0;
    mon_done = 0; mon_ab = 0; mon_gad = 2'b11; prev_done = 0; prev_grant = grant;
    mon_inq.delete(); mon_order.delete();
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
    gen_out = 8'($urandom);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int want, input int budget, input string nm);
    int k = 0;
    while (mon_ndone < want && k < budget) begin step(); k++; end
    check({nm, "_timeout"}, 32'(mon_ndone >= want), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b0; req = 2'b00;
    step();
    RST = 1'b1;
  endtask

  function automatic logic [31:0] inq_word();
    if (mon_inq.size() == 4) return {mon_inq[3], mon_inq[2], mon_inq[1], mon_inq[0]};
    return 32'h0;
  endfunction

  // ---------------- stimulus ----------------
  int k;
  initial begin
    RST = 1'b0; req = 2'b00; gen_out = 8'h00;
    pattern0 = 32'h0; pattern1 = 32'h0; n_pat0 = 8'h0; n_pat1 = 8'h0;
    len0 = '0; len1 = '0;
    mon_clear();
    step(); step();
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_gen_rst_n", 32'(gen_rst_n), 32'd0);
    check("reset_outs", {8'(out_valid), 8'(done), 8'(aborted), gen_in | gen_n_pattern}, 32'd0);
    RST = 1'b1;
    step();

    // Single job
    pattern0 = 32'hDEADBEEF; n_pat0 = 8'd3; len0 = 16'd10;
    mon_clear(); req = 2'b01;
    wait_done(1, 60, "single");
    req = 2'b00;
    step();
    check("single_rst_low", 32'(mon_rstlow), 32'd2);
    check("single_load_bytes", inq_word(), 32'hDEADBEEF);
    check("single_beats", 32'(mon_beats), 32'd10);
    check("single_done", {31'(mon_done), mon_ab}, {31'(2'b01), 1'b0});
    check("single_grant_after", 32'(mon_gad), 32'd0);
    check("single_npattern", 32'(gen_n_pattern), 32'd3);

    // Contention, both held: 0,1,0,1 with one idle cycle between jobs
    do_reset();
    len0 = 16'd4; len1 = 16'd4;
    mon_clear(); req = 2'b11;
    wait_done(4, 200, "contention");
    req = 2'b00;
    check("contention_order", (mon_order.size() >= 4) ?
          32'({mon_order[3], mon_order[2], mon_order[1], mon_order[0]}) : 32'h0, 32'h99);
    check("contention_idle", 32'(mon_idle), 32'd3);
    step(); step();

    // len1 = 0
    pattern1 = 32'($urandom) | 32'h01010101; len1 = '0;
    mon_clear(); req = 2'b10;
    wait_done(1, 40, "len0");
    check("len0_gcycles", 32'(mon_gcycles), 32'(RST_CYC + 6));
    req = 2'b00;
    step();
    check("len0_beats", 32'(mon_beats), 32'd0);
    check("len0_loads", 32'(mon_inq.size()), 32'd4);
    check("len0_done", {31'(mon_done), mon_ab}, {31'(2'b10), 1'b0});

    // Abort after 3 beats
`ifdef PRBS_SCHED_STATS_EN
    check("stats_before_abort", 32'(jobs0), 32'd2);
`endif
    len0 = 16'd20;
    mon_clear(); req = 2'b01;
    k = 0;
    while (mon_beats < 3 && k < 50) begin step(); k++; end
    req = 2'b00;
    wait_done(1, 10, "abort");
    step(); step();
    check("abort_beats", 32'(mon_beats), 32'd3);
    check("abort_done", {31'(mon_done), mon_ab}, {31'(2'b01), 1'b1});
`ifdef PRBS_SCHED_STATS_EN
    check("stats_after_abort", 32'(jobs0), 32'd2);
`endif

    // Reset mid-LOAD (rr points at requester 1 beforehand)
    len0 = 16'd3; len1 = 16'd3;
    mon_clear(); req = 2'b01;
    k = 0;
    while (gen_in == 8'h00 && k < 20) begin step(); k++; end
    check("midload_reached", 32'(gen_in != 8'h00), 32'd1);
    mon_clear();
    RST = 1'b0;
    step();
    check("midload_reset_outs",
          {6'(grant), 2'(done), 8'(gen_in), 8'(gen_n_pattern), 4'(out_valid), 4'(gen_rst_n)}, 32'd0);
    RST = 1'b1; req = 2'b11;
    k = 0;
    while (mon_order.size() == 0 && k < 10) begin step(); k++; end
    check("midload_no_done", 32'(mon_ndone), 32'd0);
    check("midload_first_grant", (mon_order.size() > 0) ? 32'(mon_order[0]) : 32'h0, 32'd1);
    wait_done(2, 60, "midload_jobs");
    req = 2'b00;
    step();

    // Config change after grant is ignored
    pattern0 = 32'hDEADBEEF; n_pat0 = 8'd7; len0 = 16'd2;
    mon_clear(); req = 2'b01;
    k = 0;
    while (grant == 2'b00 && k < 5) begin step(); k++; end
    pattern0 = 32'h01234567; n_pat0 = 8'h55; len0 = 16'd9;
    wait_done(1, 40, "cfg");
    req = 2'b00;
    step();
    check("cfg_load_bytes", inq_word(), 32'hDEADBEEF);
    check("cfg_beats", 32'(mon_beats), 32'd2);
    check("cfg_npattern", 32'(gen_n_pattern), 32'd7);

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      RST = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (done[i]) req[i] = ($urandom_range(0, 3) == 0);
          else if ($urandom_range(0, 79) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          pattern0 = $urandom; n_pat0 = 8'($urandom); len0 = LEN_W'($urandom_range(0, 12));
        end else begin
          pattern1 = $urandom; n_pat1 = 8'($urandom); len1 = LEN_W'($urandom_range(0, 12));
        end
      end
      step();
    end
    RST = 1'b1; req = 2'b00;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
